// File: rtl/dense_backward_q_gen_if.sv
// Bus bundle for dense_backward_q_gen.
// master : job requester plus weight memory (drives start/abort/accum/d/rdata)
// slave  : the q generator (drives raddr/busy/valid/q)
// Signals:
//   start, abort, accum : job control
//   d      : BATCH rows of OUT_DIM gradient elements, packed row-major
//   raddr  : weight memory word address
//   rdata  : weight word of DATA_N lanes, valid one cycle after raddr
//   busy   : job in progress
//   valid  : q holds a completed result
//   q      : BATCH rows of IN_DIM results, packed row-major
interface dense_backward_q_gen_if #(
    parameter int BATCH      = 2,
    parameter int IN_DIM     = 32,
    parameter int OUT_DIM    = 256,
    parameter int DATA_N     = 16,
    parameter int DW         = 16,
    parameter int WW         = 16,
    parameter int QW         = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                          start;
    logic                          abort;
    logic                          accum;
    logic [BATCH*OUT_DIM*DW-1:0]   d;
    logic [ADDR_WIDTH-1:0]         raddr;
    logic [DATA_N*WW-1:0]          rdata;
    logic                          busy;
    logic                          valid;
    logic [BATCH*IN_DIM*QW-1:0]    q;

    modport master (
        output start, abort, accum, d, rdata,
        input  raddr, busy, valid, q
    );

    modport slave (
        input  start, abort, accum, d, rdata,
        output raddr, busy, valid, q
    );
endinterface

// File: rtl/dense_backward_q_gen.sv
// Dense-layer backward pass: q[b][h] = sum_c d[b][c] * W[h][c].
// Weights stream from an external memory, DATA_N lanes per word, word-major
// over (h, c). Each word feeds all BATCH rows at once; results are rounded
// half-up, shifted by FRAC and saturated to QW bits.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dense_backward_q_gen_if.slave (start/abort/accum/d/rdata in,
//           raddr/busy/valid/q out)
module dense_backward_q_gen #(
    parameter int BATCH      = 2,
    parameter int IN_DIM     = 32,
    parameter int OUT_DIM    = 256,
    parameter int DATA_N     = 16,
    parameter int DW         = 16,
    parameter int WW         = 16,
    parameter int QW         = 16,
    parameter int FRAC       = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dense_backward_q_gen_if.slave  bus
);
    localparam int NW     = IN_DIM * OUT_DIM / DATA_N;
    localparam int WPR    = OUT_DIM / DATA_N;
    localparam int AW_MAC = DW + WW + $clog2(OUT_DIM) + 1;
    localparam int AW_Q   = QW + FRAC + 1;
    // One spare bit above the larger need so the rounding add cannot wrap.
    localparam int AW     = ((AW_MAC > AW_Q) ? AW_MAC : AW_Q) + 1;

    localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC - 1);
    localparam logic signed [AW-1:0] QMAX = (AW'(1) << (QW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] QMIN = ~QMAX;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [ADDR_WIDTH-1:0]       raddr_p0;
    logic [BATCH*OUT_DIM*DW-1:0] d_p0;
    logic                        vld_p1;
    logic [ADDR_WIDTH-1:0]       word_p1;
    logic signed [AW-1:0]        acc     [BATCH][IN_DIM];
    logic signed [AW-1:0]        acc_nxt [BATCH][IN_DIM];
    logic signed [AW-1:0]        lane_sum;
    logic signed [AW-1:0]        dv;
    logic signed [AW-1:0]        wv;
    int                          row;
    int                          col;
    logic                        valid_p2;
    logic [BATCH*IN_DIM*QW-1:0]  q_p2;
    logic                        last_addr;

    function automatic logic signed [QW-1:0] round_sat(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] r;
        r = (a + HALF) >>> FRAC;
        if (r > QMAX)
            r = QMAX;
        else if (r < QMIN)
            r = QMIN;
        return r[QW-1:0];
    endfunction

    assign last_addr = (raddr_p0 == ADDR_WIDTH'(NW - 1));
    assign bus.raddr = raddr_p0;
    assign bus.busy  = (state == READ) || (state == DRAIN);
    assign bus.valid = valid_p2;
    assign bus.q     = q_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) state_nxt = READ;
                READ:       if (last_addr) state_nxt = DRAIN;
                DRAIN:      state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    // ---- stage p1: rdata of word_p1 is on the bus; MAC it into its row ----
    always_comb begin
        acc_nxt  = acc;
        lane_sum = '0;
        dv       = '0;
        wv       = '0;
        row      = int'(word_p1) / WPR;
        col      = (int'(word_p1) % WPR) * DATA_N;
        for (int b = 0; b < BATCH; b++) begin
            lane_sum = '0;
            for (int j = 0; j < DATA_N; j++) begin
                dv       = AW'($signed(d_p0[(b*OUT_DIM + col + j)*DW +: DW]));
                wv       = AW'($signed(bus.rdata[j*WW +: WW]));
                lane_sum = lane_sum + dv * wv;
            end
            if (vld_p1)
                acc_nxt[b][row] = acc[b][row] + lane_sum;
        end
    end

    // ---- stage p0: operand capture (data only, no reset needed) ----
    always_ff @(posedge clk) begin
        if ((state == IDLE || state == DONE) && bus.start && !bus.abort)
            d_p0 <= bus.d;
        word_p1 <= raddr_p0;
    end

    // ---- stage p2: address sequencing, accumulation, result register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_p0 <= '0;
            vld_p1   <= 1'b0;
            valid_p2 <= 1'b0;
            q_p2     <= '0;
            for (int b = 0; b < BATCH; b++)
                for (int h = 0; h < IN_DIM; h++)
                    acc[b][h] <= '0;
        end else begin
            vld_p1 <= 1'b0;
            if (bus.abort) begin
                raddr_p0 <= '0;
                valid_p2 <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            raddr_p0 <= '0;
                            valid_p2 <= 1'b0;
                            // Accumulate mode seeds with the held q in accumulator scale.
                            for (int b = 0; b < BATCH; b++)
                                for (int h = 0; h < IN_DIM; h++)
                                    acc[b][h] <= bus.accum
                                        ? (AW'($signed(q_p2[(b*IN_DIM + h)*QW +: QW])) <<< FRAC)
                                        : '0;
                        end
                    end
                    READ: begin
                        vld_p1   <= 1'b1;
                        raddr_p0 <= last_addr ? '0 : raddr_p0 + ADDR_WIDTH'(1);
                        acc      <= acc_nxt;
                    end
                    DRAIN: begin
                        // Last word is folded in and rounded on the same edge.
                        acc      <= acc_nxt;
                        valid_p2 <= 1'b1;
                        for (int b = 0; b < BATCH; b++)
                            for (int h = 0; h < IN_DIM; h++)
                                q_p2[(b*IN_DIM + h)*QW +: QW] <= round_sat(acc_nxt[b][h]);
                    end
                    default: raddr_p0 <= '0;
                endcase
            end
        end
    end
endmodule
